// File: rtl/vga_pkg.sv
// Character-code constants shared by the VGA text path.
// Codes follow ASCII so the font ROM can be indexed directly with addr[10:4].
package vga_pkg;

  localparam int CHAR_CODE_W = 7;
  typedef logic [CHAR_CODE_W-1:0] char_code_t;

  localparam char_code_t CHAR_SPACE = 7'h20;
  localparam char_code_t CHAR_0     = 7'h30;
  localparam char_code_t CHAR_A     = 7'h41;
  localparam char_code_t CHAR_E     = 7'h45;
  localparam char_code_t CHAR_G     = 7'h47;
  localparam char_code_t CHAR_M     = 7'h4D;
  localparam char_code_t CHAR_O     = 7'h4F;
  localparam char_code_t CHAR_P     = 7'h50;
  localparam char_code_t CHAR_R     = 7'h52;
  localparam char_code_t CHAR_V     = 7'h56;
  localparam char_code_t CHAR_W     = 7'h57;
  localparam char_code_t CHAR_Y     = 7'h59;
  localparam char_code_t CHAR_Z     = 7'h5A;

  // Digit 0..9 to its character code, for score/level readouts.
  function automatic char_code_t digit_code(input logic [3:0] digit);
    return CHAR_0 + char_code_t'(digit);
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port cell memory: one write port, one registered read-first read port.
// The array has no reset so it maps onto block RAM or LUT RAM.
module text_ram #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// 16x16 character-cell buffer for VGA text overlays: cursor-based write port,
// registered read port, and a full clear sweep after reset or on request.
module text_buffer
  import vga_pkg::*;
#(
  parameter int                CODE_W     = CHAR_CODE_W,
  parameter int                CELLS_X    = 16,
  parameter int                CELLS_Y    = 16,
  parameter logic [CODE_W-1:0] CLEAR_CHAR = CHAR_SPACE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        char_xy,
  output logic [CODE_W-1:0] char_code,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_mode,
  input  logic [7:0]        wr_data,
  input  logic              clear_req,
  output logic              busy
);

  localparam int         DEPTH     = CELLS_X * CELLS_Y;
  localparam logic [7:0] LAST_CELL = 8'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [7:0]        cursor_reg, cursor_next;
  logic              rd_busy_reg;
  logic              wr_fire;
  logic              ram_we;
  logic [7:0]        ram_waddr;
  logic [CODE_W-1:0] ram_wdata;
  logic [CODE_W-1:0] ram_rdata;

  assign busy     = (state_reg == CLEAR);
  assign wr_ready = (state_reg == IDLE) && !clear_req;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    cursor_next = cursor_reg;
    ram_we      = 1'b0;
    ram_waddr   = cursor_reg;
    ram_wdata   = wr_data[CODE_W-1:0];
    case (state_reg)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_reg;
        ram_wdata = CLEAR_CHAR;
        cnt_next  = cnt_reg + 8'd1;
        if (cnt_reg == LAST_CELL) begin
          state_next  = IDLE;
          cursor_next = 8'd0;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = 8'd0;
        end else if (wr_fire) begin
          if (wr_mode) begin
            cursor_next = wr_data;
          end else begin
            ram_we      = 1'b1;
            cursor_next = cursor_reg + 8'd1;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      cnt_reg     <= 8'd0;
      cursor_reg  <= 8'd0;
      rd_busy_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cursor_reg  <= cursor_next;
      rd_busy_reg <= busy;
    end
  end

  text_ram #(
    .DATA_W(CODE_W),
    .ADDR_W(8)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(char_xy),
    .rdata(ram_rdata)
  );

  // A read launched during the sweep may return a half-cleared cell, so it is
  // masked both while busy and for the read that was sampled while busy.
  assign char_code = (busy || rd_busy_reg) ? CLEAR_CHAR : ram_rdata;

endmodule
